// File: rtl/fb_arbiter_if.sv
// rtl/fb_arbiter_if.sv - framebuffer arbiter bus: timing generator, writers, RAM and pin-side outputs
interface fb_arbiter_if #(
   parameter int ADDR_W = 17
);
   logic [9:0]        pixel_x;
   logic [9:0]        pixel_y;
   logic              display_on;
   logic              hsync_in;
   logic              vsync_in;
   logic [1:0]        wr_req;
   logic [ADDR_W-1:0] wr_addr0;
   logic [ADDR_W-1:0] wr_addr1;
   logic [11:0]       wr_data0;
   logic [11:0]       wr_data1;
   logic [1:0]        wr_gnt;
   logic              wr_err;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [11:0]       mem_wdata;
   logic [11:0]       mem_rdata;
   logic [11:0]       rgb;
   logic              hsync_out;
   logic              vsync_out;

   modport slave (
      input  pixel_x, pixel_y, display_on, hsync_in, vsync_in,
      input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1, mem_rdata,
      output wr_gnt, wr_err, mem_addr, mem_we, mem_wdata, rgb, hsync_out, vsync_out
   );

   modport master (
      output pixel_x, pixel_y, display_on, hsync_in, vsync_in,
      output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1, mem_rdata,
      input  wr_gnt, wr_err, mem_addr, mem_we, mem_wdata, rgb, hsync_out, vsync_out
   );
endinterface

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port framebuffer RAM arbiter: scanout owns active video, writers share blanking
module fb_arbiter #(
   parameter int H_DISPLAY = 320,
   parameter int V_DISPLAY = 240,
   parameter int FB_WORDS  = H_DISPLAY * V_DISPLAY,
   parameter int ADDR_W    = 17
) (
   input logic         clk,
   input logic         reset_n,
   fb_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      CYC_IDLE,
      CYC_SCAN,
      CYC_WRITE
   } cyc_e;

   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [11:0]       mem_wdata_q, mem_wdata_d;
   logic [1:0]        wr_gnt_q, wr_gnt_d;
   logic              wr_err_q, wr_err_d;
   logic              last_grant_q, last_grant_d;
   logic [11:0]       rgb_q, rgb_d;
   logic [1:0]        tag_q, tag_d;
   logic [2:0]        hs_q, hs_d;
   logic [2:0]        vs_q, vs_d;

   cyc_e              cyc_sel;
   logic [1:0]        elig;
   logic              win;
   logic [ADDR_W-1:0] win_addr;
   logic [11:0]       win_data;
   logic              win_ok;
   logic [ADDR_W-1:0] scan_addr;

   // A writer's request is still up in its grant cycle (it only sees wr_gnt at the
   // next edge), so the bit currently granted is masked to avoid a double write.
   always_comb begin
      elig      = bus.wr_req & ~wr_gnt_q;
      win       = (&elig) ? ~last_grant_q : elig[1];
      win_addr  = win ? bus.wr_addr1 : bus.wr_addr0;
      win_data  = win ? bus.wr_data1 : bus.wr_data0;
      win_ok    = (win_addr < ADDR_W'(FB_WORDS));
      scan_addr = (ADDR_W'(bus.pixel_y) << 8) + (ADDR_W'(bus.pixel_y) << 6)
                + ADDR_W'(bus.pixel_x);
      if (bus.display_on) begin
         cyc_sel = CYC_SCAN;
      end else if (|elig) begin
         cyc_sel = CYC_WRITE;
      end else begin
         cyc_sel = CYC_IDLE;
      end
   end

   always_comb begin
      mem_addr_d   = mem_addr_q;
      mem_we_d     = 1'b0;
      mem_wdata_d  = mem_wdata_q;
      wr_gnt_d     = 2'b00;
      wr_err_d     = 1'b0;
      last_grant_d = last_grant_q;
      unique case (cyc_sel)
         CYC_SCAN: begin
            mem_addr_d = scan_addr;
         end
         CYC_WRITE: begin
            mem_addr_d   = win_addr;
            mem_wdata_d  = win_data;
            mem_we_d     = win_ok;
            wr_err_d     = ~win_ok;
            wr_gnt_d     = win ? 2'b10 : 2'b01;
            last_grant_d = win;
         end
         default: begin
         end
      endcase
   end

   // Tag needs two stages to gate rgb; syncs need three to land with rgb at the pins.
   always_comb begin
      tag_d = {tag_q[0], bus.display_on};
      hs_d  = {hs_q[1:0], bus.hsync_in};
      vs_d  = {vs_q[1:0], bus.vsync_in};
      rgb_d = tag_q[1] ? bus.mem_rdata : 12'h000;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= 12'h000;
         wr_gnt_q     <= 2'b00;
         wr_err_q     <= 1'b0;
         last_grant_q <= 1'b1;
         rgb_q        <= 12'h000;
         tag_q        <= 2'b00;
         hs_q         <= 3'b111;
         vs_q         <= 3'b111;
      end else begin
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
         wr_gnt_q     <= wr_gnt_d;
         wr_err_q     <= wr_err_d;
         last_grant_q <= last_grant_d;
         rgb_q        <= rgb_d;
         tag_q        <= tag_d;
         hs_q         <= hs_d;
         vs_q         <= vs_d;
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.wr_gnt    = wr_gnt_q;
   assign bus.wr_err    = wr_err_q;
   assign bus.rgb       = rgb_q;
   assign bus.hsync_out = hs_q[2];
   assign bus.vsync_out = vs_q[2];

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - scoreboard bench for fb_arbiter with writer/RAM models and random blanking traffic
module tb_fb_arbiter;
   localparam int ADDR_W = 17;
   localparam int FB     = 76800;

   typedef struct {
      int          cyc;
      logic [32:0] v;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   mon_en = 1'b0;

   exp_t bq[$];
   exp_t sq[$];

   int          st[2];
   logic [16:0] wa[2];
   logic [11:0] wd[2];
   int          m_last;
   logic [16:0] m_addr;
   logic [11:0] m_wdata;
   bit          disp;
   int          px, py;
   bit          hs, vs;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fb_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   fb_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   function automatic logic [11:0] ram_fn(input int a);
      if (a == 645) return 12'hABC;
      return 12'((a * 13 + 7) % 4096);
   endfunction

   always @(posedge clk) bus.mem_rdata <= ram_fn(int'(bus.mem_addr));

   task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc %0d: got %h expected %h", nm, cyc, act, exp);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (bq.size() == 0 || bq[0].cyc != cyc) begin
            n_chk++;
            $display("FAIL bus_sb cyc %0d: got no expectation, required one (queue %0d)", cyc, bq.size());
         end else begin
            e = bq.pop_front();
            chk("bus", {bus.wr_gnt, bus.wr_err, bus.mem_we, bus.mem_addr, bus.mem_wdata}, e.v);
         end
         if (sq.size() == 0 || sq[0].cyc != cyc) begin
            n_chk++;
            $display("FAIL scan_sb cyc %0d: got no expectation, required one (queue %0d)", cyc, sq.size());
         end else begin
            e = sq.pop_front();
            chk("scan", 33'({bus.rgb, bus.hsync_out, bus.vsync_out}), e.v);
         end
      end
   end

   function automatic logic [16:0] rand_addr();
      int r = int'($urandom_range(0, 9));
      if (r == 0) return 17'(FB - 1);
      if (r == 1) return 17'(FB);
      if (r == 2) return 17'($urandom_range(FB, 131071));
      return 17'($urandom_range(0, FB - 1));
   endfunction

   // Writer lifecycle: 1 pending, 2 granted (pulse visible), 3 stale cycle, 0 free.
   task automatic writers(input bit w0, input bit w1, input int a0, input int a1);
      bit want[2];
      int fa[2];
      want[0] = w0; want[1] = w1; fa[0] = a0; fa[1] = a1;
      for (int w = 0; w < 2; w++) begin
         if (st[w] == 2) st[w] = 3;
         else if (st[w] == 3) st[w] = 0;
         if (st[w] == 0 && want[w]) begin
            st[w] = 1;
            wa[w] = (fa[w] >= 0) ? 17'(fa[w]) : rand_addr();
            wd[w] = 12'($urandom);
         end
      end
   endtask

   task automatic drive();
      bus.display_on = disp;
      bus.pixel_x    = 10'(px);
      bus.pixel_y    = 10'(py);
      bus.hsync_in   = hs;
      bus.vsync_in   = vs;
      bus.wr_req     = {st[1] != 0, st[0] != 0};
      bus.wr_addr0   = wa[0];
      bus.wr_addr1   = wa[1];
      bus.wr_data0   = wd[0];
      bus.wr_data1   = wd[1];
   endtask

   task automatic step();
      int          win = -1;
      logic [1:0]  g = 2'b00;
      logic        err = 1'b0;
      logic        we = 1'b0;
      exp_t        e;
      if (disp) begin
         m_addr = 17'(py * 320 + px);
      end else begin
         if (st[0] == 1 && st[1] == 1) win = (m_last == 0) ? 1 : 0;
         else if (st[0] == 1) win = 0;
         else if (st[1] == 1) win = 1;
         if (win >= 0) begin
            m_addr  = wa[win];
            m_wdata = wd[win];
            g       = (win == 0) ? 2'b01 : 2'b10;
            err     = (int'(wa[win]) >= FB);
            we      = !err;
            m_last  = win;
            st[win] = 2;
         end
      end
      e.cyc = cyc + 1;
      e.v   = {g, err, we, m_addr, m_wdata};
      bq.push_back(e);
      e.cyc = cyc + 3;
      e.v   = 33'({(disp ? ram_fn(py * 320 + px) : 12'h000), hs, vs});
      sq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input bit d, input int x, input int y, input bit h, input bit v,
                        input bit w0, input bit w1, input int a0, input int a1);
      disp = d; px = x; py = y; hs = h; vs = v;
      writers(w0, w1, a0, a1);
      drive();
      step();
   endtask

   task automatic release_reset();
      exp_t e;
      bq.delete();
      sq.delete();
      m_last  = 1;
      m_addr  = '0;
      m_wdata = '0;
      e.cyc = cyc;
      e.v   = '0;
      bq.push_back(e);
      for (int i = 0; i < 3; i++) begin
         e.cyc = cyc + i;
         e.v   = 33'({12'h000, 2'b11});
         sq.push_back(e);
      end
      reset_n = 1'b1;
      mon_en  = 1'b1;
   endtask

   task automatic mid_reset();
      mon_en = 1'b0;
      chk("pre_reset_we", 33'(bus.mem_we), 33'(1));
      #1 reset_n = 1'b0;
      #1;
      chk("rst_async", 33'({bus.mem_we, bus.wr_gnt, bus.rgb, bus.hsync_out}), 33'({1'b0, 2'b00, 12'h000, 1'b1}));
      repeat (2) @(posedge clk);
      #1;
      for (int w = 0; w < 2; w++) begin
         if (st[w] == 2) st[w] = 1;
         else if (st[w] == 3) st[w] = 0;
      end
      release_reset();
   endtask

   initial begin
      bit rd = 1'b0;
      reset_n = 1'b1;
      disp = 1'b0; px = 0; py = 0; hs = 1'b1; vs = 1'b1;
      st[0] = 0; st[1] = 0;
      wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
      drive();
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_bus", {bus.wr_gnt, bus.wr_err, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 33'(0));
      chk("rst_scan", 33'({bus.rgb, bus.hsync_out, bus.vsync_out}), 33'({12'h000, 2'b11}));
      release_reset();

      repeat (6) cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
      repeat (2) cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);

      cycle(1'b1, 5, 2, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
      for (int i = 6; i < 10; i++) cycle(1'b1, i, 2, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);

      for (int i = 0; i < 8; i++) cycle(1'b1, 20 + i, 7, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1);
      repeat (3) cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1);

      repeat (3) cycle(1'b1, 100, 50, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
      repeat (3) cycle(1'b1, 101, 50, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);
      repeat (4) cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);

      cycle(1'b1, 319, 239, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, FB, -1);
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, FB - 1, -1);
      repeat (3) cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);

      cycle(1'b1, 7, 3, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);
      cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 100, -1);
      mid_reset();
      repeat (4) cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) rd = !rd;
         cycle(rd, int'($urandom_range(0, 319)), int'($urandom_range(0, 239)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
      end
      repeat (4) cycle(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, -1, -1);
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
